io_pad_arbiter: RTL and testbench

Time-multiplexes one bidirectional SB_IO pad's output path (D_OUT_0 / OUTPUT_ENABLE) between NREQ fabric requesters. Requesters post a burst length, and the arbiter grants the pad round-robin. It then streams each winner's bits onto the pad for exactly that many cycles and inserts a turnaround gap with the output driver off before the next owner. It sits between fabric logic and the SB_IO primitive in the io_wrapper-style top level, driving the pad's D_OUT_0 and OUTPUT_ENABLE pins.

---
 rtl/io_pad_arb_pkg.sv | 32 +++
 rtl/io_pad_arb_rr_pick.sv | 56 +++++
 rtl/io_pad_arbiter.sv | 139 +++++++++++++
 tb/tb_io_pad_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pad_arb_pkg.sv
// io_pad_arb_pkg: shared types, defaults and width helpers for io_pad_arbiter.
//
// Contents:
//   arb_state_e    - arbiter FSM states (IDLE, DRIVE, TURN)
//   DEF_*          - default parameter values for the arbiter and picker
//   len_width()    - bits needed to hold a count 0..n-1 (minimum 1)
//   idx_width()    - bits needed to index n requesters (minimum 1)
//
// Optional feature macro used by the files importing this package:
//   IO_PAD_ARB_PRIO_EN - requester 0 has fixed priority over the round-robin.

package io_pad_arb_pkg;

    localparam int DEF_NREQ       = 4;
    localparam int DEF_MAXBEATS   = 16;
    localparam int DEF_TURNAROUND = 1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DRIVE = 2'd1,
        ARB_TURN  = 2'd2
    } arb_state_e;

    function automatic int len_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_pad_arb_rr_pick.sv
// io_pad_arb_rr_pick: combinational round-robin winner selection.
//
// Scans req starting at ptr and wrapping; the first set bit wins.
// With IO_PAD_ARB_PRIO_EN defined, requester 0 wins outright whenever it
// requests, and the round-robin scan only considers requesters 1..NREQ-1.
//
// Ports:
//   req      in   NREQ  request vector
//   ptr      in   PW    index the scan starts from
//   win      out  NREQ  one-hot winner (zero when nothing requests)
//   win_idx  out  PW    binary index of the winner
//   found    out  1     at least one eligible request

module io_pad_arb_rr_pick
    import io_pad_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = idx_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx,
    output logic            found
);

    logic [NREQ-1:0] cand;
    int              idx;

    always_comb begin
        cand    = req;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
`ifdef IO_PAD_ARB_PRIO_EN
        // Requester 0 is served outside the rotation.
        cand[0] = 1'b0;
        if (req[0]) begin
            win[0] = 1'b1;
            found  = 1'b1;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (!found) begin
                idx = (int'(ptr) + k) % NREQ;
                if (cand[idx]) begin
                    win[idx] = 1'b1;
                    win_idx  = idx[PW-1:0];
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/io_pad_arbiter.sv
// io_pad_arbiter: shares one SB_IO pad output path (D_OUT_0/OUTPUT_ENABLE)
// between NREQ fabric requesters. Each winner streams len+1 serial bits onto
// the pad, followed by TURNAROUND+1 cycles with the driver off before the
// next owner is driven.
//
// Build option: define IO_PAD_ARB_PRIO_EN to give requester 0 fixed priority
// (otherwise pure round-robin over all requesters).
//
// Ports:
//   clk       in   1        rising-edge clock
//   rst       in   1        asynchronous active-high reset
//   cen       in   1        clock enable; low freezes state and outputs
//   req       in   NREQ     per-requester burst request (level)
//   len       in   NREQ*LW  per-requester beats-1, field i = len[i*LW +: LW]
//   data_in   in   NREQ     per-requester serial bit
//   gnt       out  NREQ     one-hot current owner (registered)
//   take      out  NREQ     data_in[i] consumed at this edge
//   busy      out  1        arbiter not idle
//   pad_dout  out  1        to SB_IO D_OUT_0 (registered)
//   pad_oe    out  1        to SB_IO OUTPUT_ENABLE (registered)

module io_pad_arbiter
    import io_pad_arb_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int MAXBEATS   = DEF_MAXBEATS,
    parameter int TURNAROUND = DEF_TURNAROUND
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cen,
    input  logic [NREQ-1:0]                      req,
    input  logic [NREQ*len_width(MAXBEATS)-1:0]  len,
    input  logic [NREQ-1:0]                      data_in,
    output logic [NREQ-1:0]                      gnt,
    output logic [NREQ-1:0]                      take,
    output logic                                 busy,
    output logic                                 pad_dout,
    output logic                                 pad_oe
);

    localparam int LW = len_width(MAXBEATS);
    localparam int PW = idx_width(NREQ);
    localparam int TW = len_width(TURNAROUND);

    localparam logic [1:0] S_IDLE  = ARB_IDLE;
    localparam logic [1:0] S_DRIVE = ARB_DRIVE;
    localparam logic [1:0] S_TURN  = ARB_TURN;

    logic [1:0]      state;
    logic [LW-1:0]   cnt;
    logic [TW-1:0]   tcnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   own;

    logic [NREQ-1:0] pick_win;
    logic [PW-1:0]   pick_idx;
    logic            pick_found;
    logic [LW-1:0]   pick_len;
    logic [PW-1:0]   next_ptr;
    logic            adv_ptr;

    io_pad_arb_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .found   (pick_found)
    );

    assign pick_len = len[int'(pick_idx)*LW +: LW];
    assign next_ptr = (int'(pick_idx) == NREQ-1) ? '0 : pick_idx + 1'b1;

`ifdef IO_PAD_ARB_PRIO_EN
    // Requester-0 grants sit outside the rotation, so they leave ptr alone.
    assign adv_ptr = (pick_idx != '0);
`else
    assign adv_ptr = 1'b1;
`endif

    assign busy = (state != S_IDLE);
    assign take = gnt & {NREQ{(state == S_DRIVE) && cen}};

    // Asynchronous reset: pad_oe must drop as soon as rst rises, even mid-burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            gnt      <= '0;
            ptr      <= '0;
            own      <= '0;
            cnt      <= '0;
            tcnt     <= '0;
            pad_oe   <= 1'b0;
            pad_dout <= 1'b0;
        end else if (cen) begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        gnt   <= pick_win;
                        own   <= pick_idx;
                        cnt   <= pick_len;
                        state <= S_DRIVE;
                        if (adv_ptr) begin
                            ptr <= next_ptr;
                        end
                    end
                end
                S_DRIVE: begin
                    pad_dout <= data_in[own];
                    pad_oe   <= 1'b1;
                    if (cnt == '0) begin
                        gnt   <= '0;
                        tcnt  <= TW'(TURNAROUND - 1);
                        state <= S_TURN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_TURN: begin
                    // pad_dout keeps the last driven bit while the driver is off.
                    pad_oe <= 1'b0;
                    if (tcnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_pad_arbiter.sv
// tb_io_pad_arbiter: randomized and directed bench for io_pad_arbiter with a
// burst-level reference model (owner, burst length, position in the burst
// window, round-robin pointer).

module tb_io_pad_arbiter;

    localparam int NREQ       = 4;
    localparam int MAXBEATS   = 16;
    localparam int TURNAROUND = 1;
    localparam int LW         = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cen;
    logic [NREQ-1:0]      req;
    logic [NREQ*LW-1:0]   len;
    logic [NREQ-1:0]      data_in;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      take;
    logic                 busy;
    logic                 pad_dout;
    logic                 pad_oe;

    io_pad_arbiter #(
        .NREQ       (NREQ),
        .MAXBEATS   (MAXBEATS),
        .TURNAROUND (TURNAROUND)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .req      (req),
        .len      (len),
        .data_in  (data_in),
        .gnt      (gnt),
        .take     (take),
        .busy     (busy),
        .pad_dout (pad_dout),
        .pad_oe   (pad_oe)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A burst occupies a window of enabled cycles counted from the grant:
    // positions 0..len drive the pad, len+1..len+TURNAROUND are driver-off.
    int   m_owner;
    int   m_len;
    int   m_pos;
    int   m_rr;
    logic m_oe;
    logic m_dout;

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [NREQ-1:0] m_gnt();
        return (m_owner >= 0 && m_pos <= m_len) ? onehot(m_owner) : '0;
    endfunction

    function automatic int m_pick(input logic [NREQ-1:0] r);
`ifdef IO_PAD_ARB_PRIO_EN
        if (r[0]) return 0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (i != 0 && r[i]) return i;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_len = 0; m_pos = 0; m_rr = 0; m_oe = 1'b0; m_dout = 1'b0;
    endtask

    task automatic model_step(input logic c, input logic [NREQ-1:0] r,
                              input logic [NREQ*LW-1:0] l, input logic [NREQ-1:0] d);
        int w;
        if (!c) return;
        if (m_owner < 0) begin
            w = m_pick(r);
            if (w >= 0) begin
                m_owner = w;
                m_len   = int'(l[w*LW +: LW]);
                m_pos   = 0;
`ifdef IO_PAD_ARB_PRIO_EN
                if (w != 0) m_rr = (w + 1) % NREQ;
`else
                m_rr = (w + 1) % NREQ;
`endif
            end
        end else if (m_pos <= m_len) begin
            m_dout = d[m_owner];
            m_oe   = 1'b1;
            m_pos++;
        end else begin
            m_oe = 1'b0;
            m_pos++;
            if (m_pos == m_len + 1 + TURNAROUND) m_owner = -1;
        end
    endtask

    // ---------------- observation tracking ----------------
    int   gq[$];
    int   runs[$];
    int   gaps[$];
    logic dq[$];
    int   run_len, gap_len, takes_cnt;
    bit   seen_run;
    logic [NREQ-1:0] prev_gnt;

    task automatic clear_obs();
        gq.delete(); runs.delete(); gaps.delete(); dq.delete();
        run_len = 0; gap_len = 0; takes_cnt = 0; seen_run = 0; prev_gnt = '0;
    endtask

    function automatic logic [NREQ*LW-1:0] lens(input int a0, input int a1, input int a2, input int a3);
        logic [NREQ*LW-1:0] v;
        v = '0;
        v[0*LW +: LW] = LW'(a0);
        v[1*LW +: LW] = LW'(a1);
        v[2*LW +: LW] = LW'(a2);
        v[3*LW +: LW] = LW'(a3);
        return v;
    endfunction

    // One clock: drive at negedge, check take, model the edge, check registers.
    task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*LW-1:0] l,
                         input logic [NREQ-1:0] d, input logic c);
        logic [NREQ-1:0] exp_t;
        @(negedge clk);
        req = r; len = l; data_in = d; cen = c;
        #1;
        exp_t = (c && m_owner >= 0 && m_pos <= m_len) ? onehot(m_owner) : '0;
        check_val("take", 32'(take), 32'(exp_t));
        if (take != '0) takes_cnt++;
        @(posedge clk);
        model_step(c, r, l, d);
        #1;
        check_val("gnt", 32'(gnt), 32'(m_gnt()));
        check_val("pad_oe", 32'(pad_oe), 32'(m_oe));
        check_val("pad_dout", 32'(pad_dout), 32'(m_dout));
        check_val("busy", 32'(busy), 32'(m_owner >= 0));
        if (gnt != '0 && prev_gnt == '0) begin
            for (int i = 0; i < NREQ; i++) if (gnt[i]) gq.push_back(i);
        end
        prev_gnt = gnt;
        if (c) begin
            if (pad_oe) begin
                if (run_len == 0 && seen_run) gaps.push_back(gap_len);
                run_len++;
                dq.push_back(pad_dout);
            end else begin
                if (run_len > 0) begin
                    runs.push_back(run_len);
                    run_len = 0; seen_run = 1; gap_len = 0;
                end
                gap_len++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; len = '0; data_in = '0; cen = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_obs();
    endtask

    logic [3:0]          pat;
    logic [NREQ-1:0]     d;
    logic [NREQ-1:0]     r;
    logic [31:0]         rnd;
    int                  exp_rr[5];
    bit                  got2;
    logic [NREQ-1:0]     exp_prio;

    initial begin
        rst = 1'b1; cen = 1'b0; req = '0; len = '0; data_in = '0;
        model_reset();
        clear_obs();

        // Reset state and idle with no requests.
        do_reset();
        #1;
        check_val("rst_gnt", 32'(gnt), 32'(0));
        check_val("rst_oe", 32'(pad_oe), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_dout", 32'(pad_dout), 32'(0));
        repeat (6) cycle('0, lens(3, 3, 3, 3), 4'($urandom), 1'b1);

        // Single burst on requester 2, len 3, bits 1,0,1,1.
        do_reset();
        pat = 4'b1101;
        d = 4'($urandom);
        cycle(4'b0100, lens(0, 0, 3, 0), d, 1'b1);
        check_val("single_gnt", 32'(gnt), 32'(4'b0100));
        for (int c = 0; c < 8; c++) begin
            d = 4'($urandom);
            if (m_owner == 2 && m_pos <= m_len) d[2] = pat[m_pos];
            cycle('0, lens(9, 9, 9, 9), d, 1'b1);
        end
        check_val("single_beats", 32'(dq.size()), 32'(4));
        for (int i = 0; i < dq.size() && i < 4; i++) check_val("single_bit", 32'(dq[i]), 32'(pat[i]));
        check_val("single_runs", 32'(runs.size()), 32'(1));

        // Round-robin fairness: all request, len 0.
        do_reset();
`ifdef IO_PAD_ARB_PRIO_EN
        exp_rr = '{0, 0, 0, 0, 0};
`else
        exp_rr = '{0, 1, 2, 3, 0};
`endif
        repeat (16) cycle(4'b1111, lens(0, 0, 0, 0), 4'($urandom), 1'b1);
        check_val("rr_count", 32'(gq.size() >= 5), 32'(1));
        for (int i = 0; i < gq.size() && i < 5; i++) check_val("rr_order", 32'(gq[i]), 32'(exp_rr[i]));
        foreach (gaps[i]) check_val("rr_gap", 32'(gaps[i]), 32'(TURNAROUND + 1));
        check_val("rr_gap_seen", 32'(gaps.size() >= 3), 32'(1));

        // cen gating inside DRIVE, len 5.
        do_reset();
        cycle(4'b1000, lens(0, 0, 0, 5), 4'($urandom), 1'b1);
        repeat (2) cycle('0, lens(1, 1, 1, 1), 4'($urandom), 1'b1);
        repeat (3) cycle('0, lens(1, 1, 1, 1), 4'($urandom), 1'b0);
        repeat (8) cycle('0, lens(1, 1, 1, 1), 4'($urandom), 1'b1);
        check_val("cen_takes", 32'(takes_cnt), 32'(6));
        check_val("cen_runs", 32'(runs.size()), 32'(1));
        if (runs.size() > 0) check_val("cen_run_len", 32'(runs[0]), 32'(6));

        // Withdrawn request: requester 1 drops req after its first take.
        do_reset();
        got2 = 0;
        cycle(4'b0110, lens(0, 7, 2, 0), 4'($urandom), 1'b1);
        cycle(4'b0110, lens(0, 7, 2, 0), 4'($urandom), 1'b1);
        for (int c = 0; c < 20; c++) begin
            if (m_owner == 2) got2 = 1;
            r = got2 ? 4'b0000 : 4'b0100;
            cycle(r, lens(0, 7, 2, 0), 4'($urandom), 1'b1);
        end
        check_val("wd_grants", 32'(gq.size()), 32'(2));
        if (gq.size() == 2) begin
            check_val("wd_first", 32'(gq[0]), 32'(1));
            check_val("wd_second", 32'(gq[1]), 32'(2));
        end
        check_val("wd_runs", 32'(runs.size()), 32'(2));
        if (runs.size() == 2) begin
            check_val("wd_run0", 32'(runs[0]), 32'(8));
            check_val("wd_run1", 32'(runs[1]), 32'(3));
        end
        if (gaps.size() > 0) check_val("wd_gap", 32'(gaps[0]), 32'(TURNAROUND + 1));

        // Priority option: grant 0 first, then req=1011.
        do_reset();
        cycle(4'b0001, lens(0, 0, 0, 0), 4'($urandom), 1'b1);
        repeat (3) cycle('0, lens(0, 0, 0, 0), 4'($urandom), 1'b1);
`ifdef IO_PAD_ARB_PRIO_EN
        exp_prio = 4'b0001;
`else
        exp_prio = 4'b0010;
`endif
        cycle(4'b1011, lens(0, 0, 0, 0), 4'($urandom), 1'b1);
        check_val("prio_win", 32'(gnt), 32'(exp_prio));
        repeat (4) cycle('0, lens(0, 0, 0, 0), 4'($urandom), 1'b1);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        repeat (4) cycle(4'b0001, lens(7, 0, 0, 0), 4'($urandom), 1'b1);
        check_val("mid_oe_before", 32'(pad_oe), 32'(1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_oe", 32'(pad_oe), 32'(0));
        check_val("mid_rst_gnt", 32'(gnt), 32'(0));
        check_val("mid_rst_busy", 32'(busy), 32'(0));
        model_reset();
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_obs();
        repeat (6) cycle('0, lens(7, 0, 0, 0), 4'($urandom), 1'b1);
        check_val("mid_no_resume", 32'(takes_cnt), 32'(0));

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rnd = $urandom;
            cycle(4'($urandom), rnd[NREQ*LW-1:0], 4'($urandom), ($urandom_range(0, 9) != 0));
        end
        foreach (runs[i]) check_val("rand_run_max", 32'(runs[i] <= MAXBEATS), 32'(1));
        foreach (gaps[i]) check_val("rand_gap_min", 32'(gaps[i] >= TURNAROUND + 1), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
